cska_mp_seq: RTL

// - Multi-precision add/subtract sequencer around one shared cska32 (32-bit carry-skip adder).
// - Processes a WORDS*32-bit operand pair one 32-bit word per cycle, LSW first.
// - Carries between words in a flop; result is held until the next accepted start.
// - Sits between the CPU-side register file and the single cska32 instance of the arithmetic unit.

---
 rtl/cska_mp_seq_pkg.sv | 24 ++
 rtl/cska_mp_seq_cska32.sv | 49 ++++
 rtl/cska_mp_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/cska_mp_seq_pkg.sv
// ============================================================================
// Module  : cska_mp_seq_pkg
// Brief   : Shared constants and helpers for the multi-precision add/sub unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package cska_mp_seq_pkg;

    localparam int CSKA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Subtraction feeds the adder with the one's complement of B.
    function automatic logic [CSKA_W-1:0] word_b(input logic [CSKA_W-1:0] b,
                                                 input logic              inv);
        return inv ? ~b : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cska_mp_seq_cska32.sv
// ============================================================================
// Module  : cska32
// Brief   : 32-bit carry-skip adder, 4-bit ripple blocks with skip muxes
// Revision: 1.0
// ============================================================================
`default_nettype none

module cska32
    import cska_mp_seq_pkg::*;
(
    input  logic [CSKA_W-1:0] i_a,
    input  logic [CSKA_W-1:0] i_b,
    input  logic              i_cin,
    output logic [CSKA_W-1:0] o_sum,
    output logic              o_cout
);

    localparam int BLK  = 4;
    localparam int NBLK = CSKA_W / BLK;

    logic w_carry;
    logic w_blk_cin;
    logic w_p_all;
    logic w_p;

    // A block whose bits all propagate forwards its carry-in past the ripple.
    always_comb begin
        o_sum     = '0;
        w_carry   = i_cin;
        w_blk_cin = 1'b0;
        w_p_all   = 1'b0;
        w_p       = 1'b0;
        for (int blk = 0; blk < NBLK; blk++) begin
            w_blk_cin = w_carry;
            w_p_all   = 1'b1;
            for (int bt = 0; bt < BLK; bt++) begin
                w_p                  = i_a[blk*BLK+bt] ^ i_b[blk*BLK+bt];
                o_sum[blk*BLK+bt]    = w_p ^ w_carry;
                w_carry              = (i_a[blk*BLK+bt] & i_b[blk*BLK+bt]) | (w_p & w_carry);
                w_p_all              = w_p_all & w_p;
            end
            w_carry = w_p_all ? w_blk_cin : w_carry;
        end
        o_cout = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/cska_mp_seq.sv
// ============================================================================
// Module  : cska_mp_seq
// Brief   : Word-serial WORDS*32-bit add/subtract around one shared cska32
// Revision: 1.0
// ============================================================================
`default_nettype none

module cska_mp_seq
    import cska_mp_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op_sub,
    input  logic [WORDS*CSKA_W-1:0]   a,
    input  logic [WORDS*CSKA_W-1:0]   b,
    output logic                      ready,
    output logic                      done,
    output logic [WORDS*CSKA_W-1:0]   sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int               IDX_W    = $clog2(WORDS);
    localparam int               TOT_W    = WORDS * CSKA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_sub;
    logic [TOT_W-1:0]    r_a;
    logic [TOT_W-1:0]    r_b;
    logic [TOT_W-1:0]    r_sum;
    logic                r_cout;
    logic                r_ovf;

    logic                w_accept;
    logic [CSKA_W-1:0]   w_a_word;
    logic [CSKA_W-1:0]   w_b_word;
    logic [CSKA_W-1:0]   w_s_word;
    logic                w_co;

    assign w_accept = ready & start;
    assign w_a_word = r_a[r_idx*CSKA_W +: CSKA_W];
    assign w_b_word = word_b(r_b[r_idx*CSKA_W +: CSKA_W], r_sub);

    cska32 u_cska32 (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_s_word),
        .o_cout (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next_state = (r_idx == LAST_IDX) ? ST_DONE : ST_RUN;
            ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state != ST_RUN);
        done  = (r_state == ST_DONE);
    end

    // Datapath: operand capture on accept, one result word per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= op_sub;
            r_idx   <= '0;
            r_carry <= op_sub;
        end else if (r_state == ST_RUN) begin
            r_sum[r_idx*CSKA_W +: CSKA_W] <= w_s_word;
            r_carry                       <= w_co;
            if (r_idx == LAST_IDX) begin
                r_idx  <= '0;
                r_cout <= w_co;
                r_ovf  <= (w_a_word[CSKA_W-1] == w_b_word[CSKA_W-1]) &
                          (w_s_word[CSKA_W-1] != w_a_word[CSKA_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire
